enemy_fire_scheduler: RTL

//  Producer side of the enemy-shot interface. Periodically picks a pseudo-random column that still has

---
 rtl/space_invaders_pkg.sv | 15 +
 rtl/lfsr16.sv | 12 +
 rtl/enemy_fire_scheduler.sv | 102 ++++++++++
 3 files changed

// File: rtl/space_invaders_pkg.sv
// space_invaders_pkg: shared geometry, ID width, alive-mask indexing and fire FSM encoding
package space_invaders_pkg;
  localparam int COLUNAS = 8;
  localparam int LINHAS = 3;
  localparam int ID_W = 6;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PICK  = 2'd1,
    SCAN  = 2'd2,
    OFFER = 2'd3
  } fire_state_t;
  function automatic int alive_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11), free-running out of reset
module lfsr16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] out
);
  // right-shifting Galois form: feedback from bit 0 into the tap mask
  always_ff @(posedge clk or negedge reset)
    if (!reset) out <= seed;
    else out <= (out >> 1) ^ (out[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/enemy_fire_scheduler.sv
// enemy_fire_scheduler: periodically picks a random live column and offers its bottom-most invader as shooter
module enemy_fire_scheduler #(
  parameter int          COLUNAS     = space_invaders_pkg::COLUNAS,
  parameter int          LINHAS      = space_invaders_pkg::LINHAS,
  parameter int          FIRE_PERIOD = 10_000_000,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [COLUNAS*LINHAS-1:0]           vivo_inimigo,
  input  logic                                bala_ativa,
  input  logic                                fire_ready,
  output logic                                fire_valid,
  output logic [space_invaders_pkg::ID_W-1:0] ID_enemy_tiro_X,
  output logic [space_invaders_pkg::ID_W-1:0] ID_enemy_tiro_Y
);
  import space_invaders_pkg::*;
  localparam int CW = COLUNAS > 1 ? $clog2(COLUNAS) : 1;
  localparam int PW = $clog2(FIRE_PERIOD);
  localparam logic [CW:0] NCOL = (CW+1)'(COLUNAS);
  localparam logic [PW-1:0] TC = PW'(FIRE_PERIOD - 1);
  fire_state_t state;
  logic [15:0] lfsr;
  logic [PW-1:0] cnt;
  logic [CW-1:0] scan_col, cand_col;
  logic [CW:0] scan_cnt, cand_ext;
  logic [LINHAS-1:0] col_alive;
  logic found;
  logic [ID_W-1:0] hit_row;
  logic unused_lfsr;
  lfsr16 u_lfsr (
    .clk  (clk),
    .reset(reset),
    .seed (LFSR_SEED),
    .out  (lfsr)
  );
  assign unused_lfsr = ^lfsr[15:CW];
  assign cand_ext = {1'b0, lfsr[CW-1:0]};
  assign cand_col = cand_ext >= NCOL ? CW'(cand_ext - NCOL) : lfsr[CW-1:0];
  for (genvar r = 0; r < LINHAS; r++) begin : g_row
    logic [COLUNAS-1:0] row_bits;
    assign row_bits = vivo_inimigo[alive_idx(r, 0, COLUNAS) +: COLUNAS];
    assign col_alive[r] = row_bits[scan_col];
  end
  // bottom-most live row of the column under scan (later rows win)
  always_comb begin
    found = 1'b0;
    hit_row = '0;
    for (int i = 0; i < LINHAS; i++)
      if (col_alive[i]) begin
        found = 1'b1;
        hit_row = ID_W'(i);
      end
  end
  // fire FSM: period count, column pick, column scan, handshake offer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      scan_col <= '0;
      scan_cnt <= '0;
      fire_valid <= 1'b0;
      ID_enemy_tiro_X <= '0;
      ID_enemy_tiro_Y <= '0;
    end else if (!enable) begin
      state <= IDLE;
      cnt <= '0;
      fire_valid <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (cnt != TC) cnt <= cnt + 1'b1;
          else if (!bala_ativa) begin
            cnt <= '0;
            state <= PICK;
          end
        PICK: begin
          scan_col <= cand_col;
          scan_cnt <= '0;
          state <= SCAN;
        end
        SCAN:
          if (found) begin
            ID_enemy_tiro_X <= ID_W'(scan_col);
            ID_enemy_tiro_Y <= hit_row + 1'b1;
            fire_valid <= 1'b1;
            state <= OFFER;
          end else begin
            scan_col <= scan_col == CW'(COLUNAS - 1) ? '0 : scan_col + 1'b1;
            scan_cnt <= scan_cnt + 1'b1;
            if (scan_cnt == NCOL - 1'b1) state <= IDLE;
          end
        OFFER:
          if (fire_ready) begin
            fire_valid <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
